// File: rtl/reg_file_wb.sv
// 32-entry register file fed by writeback, read by decode, plus a debug port.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback to ReadData1/2.
module reg_file_wb #(
  parameter int Width = 32,
  parameter int AddrW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWrite,
  input  logic [AddrW-1:0] rd,
  input  logic [Width-1:0] Writeback,
  input  logic [AddrW-1:0] rs,
  input  logic [AddrW-1:0] rt,
  output logic [Width-1:0] ReadData1,
  output logic [Width-1:0] ReadData2,
  input  logic [AddrW-1:0] dbg_addr,
  output logic [Width-1:0] dbg_data,
  output logic [15:0]      wr_count
);

  localparam int Depth = 2 ** AddrW;

  logic [Width-1:0] regs_q [Depth];
  logic [15:0]      wr_count_q;
  logic [15:0]      wr_count_d;
  logic             we;

  assign we = RegWrite && (rd != '0);

  always_comb begin
    wr_count_d = wr_count_q;
    if (we && (wr_count_q != 16'hFFFF))
      wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++)
        regs_q[i] <= '0;
      wr_count_q <= '0;
    end else begin
      if (we)
        regs_q[rd] <= Writeback;
      wr_count_q <= wr_count_d;
    end
  end

  function automatic logic [Width-1:0] arr_rd(
    input logic [AddrW-1:0] a
  );
    return (a == '0) ? '0 : regs_q[a];
  endfunction

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    ReadData1 = arr_rd(rs);
    ReadData2 = arr_rd(rt);
    if (we && (rs == rd))
      ReadData1 = Writeback;
    if (we && (rt == rd))
      ReadData2 = Writeback;
  end
`else
  always_comb begin
    ReadData1 = arr_rd(rs);
    ReadData2 = arr_rd(rt);
  end
`endif

  assign dbg_data = arr_rd(dbg_addr);
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb.
// Hazard expectations follow REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] Writeback;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [15:0] wr_count;

  int passed = 0;
  int total  = 0;

  reg_file_wb dut (
    .clk(clk), .rst(rst),
    .RegWrite(RegWrite), .rd(rd),
    .Writeback(Writeback),
    .rs(rs), .rt(rt),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    RegWrite = 1'b1; rd = a; Writeback = d;
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_write(5'd4, 32'hA5A5A5A5);
    do_write(5'd31, 32'h0000_0011);
    @(negedge clk);
    RegWrite = 1'b1; rd = 5'd9; Writeback = 32'h99;
    #1 rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #0.1;
      total++;
      if (dbg_data !== 32'h0)
        $display("FAIL reset_dbg[%0d] got %h want 0", i, dbg_data);
      else passed++;
    end
    total++;
    if (wr_count !== 16'h0)
      $display("FAIL reset_cnt got %h want 0", wr_count);
    else passed++;
    @(negedge clk);
    RegWrite = 1'b0;
    rst = 1'b0;
    dbg_addr = 5'd9;
    #1;
    total++;
    if (dbg_data !== 32'h0 || wr_count !== 16'h0)
      $display("FAIL reset_drop got %h/%h want 0/0", dbg_data, wr_count);
    else passed++;
  endtask

  task automatic test_write_read();
    rs = 5'd5;
    #1;
    total++;
    if (ReadData1 !== 32'h0)
      $display("FAIL wr_pre got %h want 0", ReadData1);
    else passed++;
    do_write(5'd5, 32'hDEADBEEF);
    total++;
    if (ReadData1 !== 32'hDEADBEEF)
      $display("FAIL wr_data got %h want deadbeef", ReadData1);
    else passed++;
    total++;
    if (wr_count !== 16'd1)
      $display("FAIL wr_cnt got %0d want 1", wr_count);
    else passed++;
  endtask

  task automatic test_r0_guard();
    do_write(5'd0, 32'hFFFFFFFF);
    rs = 5'd0; rt = 5'd0; dbg_addr = 5'd0;
    #1;
    total++;
    if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0 || dbg_data !== 32'h0)
      $display("FAIL r0_read got %h/%h/%h want 0", ReadData1, ReadData2, dbg_data);
    else passed++;
    total++;
    if (wr_count !== 16'd1)
      $display("FAIL r0_cnt got %0d want 1", wr_count);
    else passed++;
  endtask

  task automatic test_hazard();
    logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'd2;
`else
    exp_same = 32'd1;
`endif
    do_write(5'd7, 32'd1);
    @(negedge clk);
    RegWrite = 1'b1; rd = 5'd7; Writeback = 32'd2;
    rt = 5'd7; rs = 5'd7; dbg_addr = 5'd7;
    #1;
    total++;
    if (ReadData2 !== exp_same)
      $display("FAIL haz_rt got %h want %h", ReadData2, exp_same);
    else passed++;
    total++;
    if (ReadData1 !== exp_same)
      $display("FAIL haz_rs got %h want %h", ReadData1, exp_same);
    else passed++;
    total++;
    if (dbg_data !== 32'd1)
      $display("FAIL haz_dbg got %h want 1", dbg_data);
    else passed++;
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    total++;
    if (ReadData2 !== 32'd2)
      $display("FAIL haz_next got %h want 2", ReadData2);
    else passed++;
  endtask

  task automatic test_dual_port();
    do_write(5'd3, 32'h12345678);
    rs = 5'd3; rt = 5'd3;
    #1;
    total++;
    if (ReadData1 !== 32'h12345678 || ReadData2 !== 32'h12345678)
      $display("FAIL dual got %h/%h want 12345678", ReadData1, ReadData2);
    else passed++;
    rs = 5'd5;
    #1;
    total++;
    if (ReadData1 !== 32'hDEADBEEF || ReadData2 !== 32'h12345678)
      $display("FAIL dual_diff got %h/%h want deadbeef/12345678",
               ReadData1, ReadData2);
    else passed++;
  endtask

  task automatic write_n(input int n);
    @(negedge clk);
    RegWrite = 1'b1; rd = 5'd1; Writeback = 32'h5;
    repeat (n) @(posedge clk);
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    write_n(65534);
    total++;
    if (wr_count !== 16'hFFFE)
      $display("FAIL sat_pre got %h want fffe", wr_count);
    else passed++;
    write_n(1);
    total++;
    if (wr_count !== 16'hFFFF)
      $display("FAIL sat_hit got %h want ffff", wr_count);
    else passed++;
    write_n(3);
    total++;
    if (wr_count !== 16'hFFFF)
      $display("FAIL sat_hold got %h want ffff", wr_count);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; RegWrite = 1'b0; rd = '0; Writeback = '0;
    rs = '0; rt = '0; dbg_addr = '0;
    #1;
    total++;
    if (wr_count !== 16'h0 || ReadData1 !== 32'h0)
      $display("FAIL init got %h/%h want 0/0", wr_count, ReadData1);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    test_write_read();
    test_r0_guard();
    test_hazard();
    test_dual_port();
    test_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
